// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: pad synchronisation, glitch filtering and 11-bit frame
// deserialisation, handing good bytes to a valid/ready consumer with one-cycle error pulses.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       hclk_i,
    input  logic       hrst_i,
    input  logic       en_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       par_err_o,
    output logic       frm_err_o,
    output logic       to_err_o,
    output logic       ovf_o
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line 0 is the PS/2 clock, line 1 the PS/2 data.
    logic          pad       [2];
    logic          sync1_reg [2];
    logic          sync2_reg [2];
    logic          filt_reg  [2];
    logic          filt_next [2];
    logic [FW-1:0] filt_cnt_reg [2];

    assign pad[0] = ps2_clk_i;
    assign pad[1] = ps2_dat_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            assign filt_next[gi] = (sync2_reg[gi] != filt_reg[gi] && filt_cnt_reg[gi] == FILT_MAX)
                                   ? sync2_reg[gi] : filt_reg[gi];

            // Idle-high reset keeps the first post-reset sample from looking like a fall.
            always_ff @(posedge hclk_i) begin
                if (hrst_i) begin
                    sync1_reg[gi]    <= 1'b1;
                    sync2_reg[gi]    <= 1'b1;
                    filt_reg[gi]     <= 1'b1;
                    filt_cnt_reg[gi] <= '0;
                end else begin
                    sync1_reg[gi] <= pad[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    filt_reg[gi]  <= filt_next[gi];
                    if (sync2_reg[gi] == filt_reg[gi] || filt_cnt_reg[gi] == FILT_MAX)
                        filt_cnt_reg[gi] <= '0;
                    else
                        filt_cnt_reg[gi] <= filt_cnt_reg[gi] + FW'(1);
                end
            end
        end
    endgenerate

    logic fall;
    logic dat;

    assign fall = filt_reg[0] & ~filt_next[0];
    assign dat  = filt_reg[1];

    state_t        state_reg, state_next;
    logic [2:0]    bitcnt_reg, bitcnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          par_reg, par_next;
    logic [TW-1:0] to_cnt_reg;

    logic good_byte;
    logic par_fail;
    logic frm_fail;
    logic to_hit;

    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        par_next    = par_reg;
        good_byte   = 1'b0;
        par_fail    = 1'b0;
        frm_fail    = 1'b0;
        to_hit      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fall && !dat) begin
                    state_next  = DATA;
                    bitcnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next[bitcnt_reg] = dat;
                    if (bitcnt_reg == 3'd7)
                        state_next = PARITY;
                    else
                        bitcnt_next = bitcnt_reg + 3'd1;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_next   = dat;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (!dat)
                        frm_fail = 1'b1;
                    else if (^{shift_reg, par_reg} == 1'b0)
                        par_fail = 1'b1;
                    else
                        good_byte = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fall strobe in the same cycle as the timeout keeps the frame alive.
        if (state_reg != IDLE && !fall && to_cnt_reg == TO_MAX) begin
            to_hit     = 1'b1;
            state_next = IDLE;
        end

        // Disabling drops any frame in flight without reporting anything.
        if (!en_i) begin
            state_next = IDLE;
            good_byte  = 1'b0;
            par_fail   = 1'b0;
            frm_fail   = 1'b0;
            to_hit     = 1'b0;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            state_reg  <= IDLE;
            bitcnt_reg <= 3'd0;
            shift_reg  <= 8'd0;
            par_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            par_reg    <= par_next;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (hrst_i || state_reg == IDLE || fall || to_hit || !en_i)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + TW'(1);
    end

    logic out_free;
    assign out_free = ~valid_o | ready_i;

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            data_o    <= 8'd0;
            valid_o   <= 1'b0;
            par_err_o <= 1'b0;
            frm_err_o <= 1'b0;
            to_err_o  <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            if (good_byte && out_free) begin
                data_o  <= shift_reg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            ovf_o     <= good_byte & ~out_free;
            par_err_o <= par_fail;
            frm_err_o <= frm_fail;
            to_err_o  <= to_hit;
        end
    end

    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: bit-bangs PS/2 frames on the pads and checks bytes,
// handshake and error pulses against hand-computed expectations.
module tb_ps2_rx_frame;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam int HALF        = 8;

    logic       hclk = 1'b0;
    logic       hrst = 1'b1;
    logic       en = 1'b1;
    logic       pclk = 1'b1;
    logic       pdat = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, busy_o, par_err_o, frm_err_o, to_err_o, ovf_o;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int n_valid = 0, n_accept = 0, n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
    int b_valid, b_accept, b_par, b_frm, b_to, b_ovf;
    logic [7:0] got_data = 8'h00;

    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .hclk_i   (hclk),
        .hrst_i   (hrst),
        .en_i     (en),
        .ps2_clk_i(pclk),
        .ps2_dat_i(pdat),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready),
        .busy_o   (busy_o),
        .par_err_o(par_err_o),
        .frm_err_o(frm_err_o),
        .to_err_o (to_err_o),
        .ovf_o    (ovf_o)
    );

    always #5 hclk = ~hclk;

    always @(negedge hclk) begin
        if (valid_o) n_valid++;
        if (valid_o && ready) begin
            n_accept++;
            got_data = data_o;
        end
        if (par_err_o) n_par++;
        if (frm_err_o) n_frm++;
        if (to_err_o)  n_to++;
        if (ovf_o)     n_ovf++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hclk);
            #2;
        end
    endtask

    task automatic mark();
        b_valid = n_valid; b_accept = n_accept; b_par = n_par;
        b_frm = n_frm; b_to = n_to; b_ovf = n_ovf;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // glitch_after >= 0 inserts a (FILTER_LEN-1)-cycle low pulse in the high phase after that bit.
    task automatic send_frame(input logic [10:0] bits, input int nbits, input int glitch_after);
        $display("tx frame bits=%03h nbits=%0d glitch_after=%0d", bits, nbits, glitch_after);
        for (int i = 0; i < nbits; i++) begin
            pdat = bits[i];
            tick(HALF);
            pclk = 1'b0;
            tick(HALF);
            pclk = 1'b1;
            if (i == glitch_after) begin
                tick(HALF);
                pclk = 1'b0;
                tick(FILTER_LEN - 1);
                pclk = 1'b1;
            end
        end
        tick(HALF);
        pdat = 1'b1;
        tick(20);
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        tick(5);
        if (data_o !== 8'h00) begin $display("FAIL reset_data: got %02h expected 00", data_o); err_cnt++; end
        cmp_cnt++;
        if (valid_o !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", valid_o); err_cnt++; end
        cmp_cnt++;
        if (busy_o !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy_o); err_cnt++; end
        cmp_cnt++;
        if ({par_err_o, frm_err_o, to_err_o, ovf_o} !== 4'b0000) begin
            $display("FAIL reset_pulses: got %b expected 0000", {par_err_o, frm_err_o, to_err_o, ovf_o});
            err_cnt++;
        end
        cmp_cnt++;
        mark();
        hrst = 1'b0;
        tick(12);
        if (busy_o !== 1'b0) begin $display("FAIL post_reset_busy: got %b expected 0", busy_o); err_cnt++; end
        cmp_cnt++;
        if ((n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf) !== 0) begin
            $display("FAIL post_reset_pulses: got %0d expected 0", (n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf));
            err_cnt++;
        end
        cmp_cnt++;
    endtask

    task automatic test_good_byte();
        int k;
        ready = 1'b1;
        mark();
        send_frame(mk(8'h1C, 1'b0, 1'b1), 10, -1);
        tick(HALF);
        pclk = 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge hclk);
            if (valid_o) begin
                k = c;
                break;
            end
        end
        if (k < FILTER_LEN + 2 || k > FILTER_LEN + 4) begin
            $display("FAIL latency: got %0d cycles expected %0d..%0d", k, FILTER_LEN + 2, FILTER_LEN + 4);
            err_cnt++;
        end
        cmp_cnt++;
        tick(HALF);
        pclk = 1'b1;
        tick(20);
        if (got_data !== 8'h1C) begin $display("FAIL good_data: got %02h expected 1c", got_data); err_cnt++; end
        cmp_cnt++;
        if (n_valid - b_valid !== 1) begin $display("FAIL good_valid_len: got %0d expected 1", n_valid - b_valid); err_cnt++; end
        cmp_cnt++;
        if ((n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf) !== 0) begin
            $display("FAIL good_no_err: got %0d expected 0", (n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf));
            err_cnt++;
        end
        cmp_cnt++;
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        mark();
        send_frame(mk(8'hF0, 1'b1, 1'b1), 11, -1);
        send_frame(mk(8'h1C, 1'b0, 1'b1), 11, -1);
        if (valid_o !== 1'b1) begin $display("FAIL ovf_valid_held: got %b expected 1", valid_o); err_cnt++; end
        cmp_cnt++;
        if (data_o !== 8'hF0) begin $display("FAIL ovf_data_held: got %02h expected f0", data_o); err_cnt++; end
        cmp_cnt++;
        if (n_ovf - b_ovf !== 1) begin $display("FAIL ovf_pulse: got %0d expected 1", n_ovf - b_ovf); err_cnt++; end
        cmp_cnt++;
        ready = 1'b1;
        tick(2);
        if (valid_o !== 1'b0) begin $display("FAIL ovf_drain_valid: got %b expected 0", valid_o); err_cnt++; end
        cmp_cnt++;
        if (n_accept - b_accept !== 1) begin $display("FAIL ovf_accepts: got %0d expected 1", n_accept - b_accept); err_cnt++; end
        cmp_cnt++;
        if (got_data !== 8'hF0) begin $display("FAIL ovf_drain_data: got %02h expected f0", got_data); err_cnt++; end
        cmp_cnt++;
    endtask

    task automatic test_errors();
        ready = 1'b1;
        mark();
        send_frame(mk(8'h1C, 1'b1, 1'b1), 11, -1);
        if (n_par - b_par !== 1) begin $display("FAIL par_pulse: got %0d expected 1", n_par - b_par); err_cnt++; end
        cmp_cnt++;
        if (n_valid - b_valid !== 0) begin $display("FAIL par_no_valid: got %0d expected 0", n_valid - b_valid); err_cnt++; end
        cmp_cnt++;
        mark();
        send_frame(mk(8'h1C, 1'b0, 1'b0), 11, -1);
        if (n_frm - b_frm !== 1) begin $display("FAIL frm_pulse: got %0d expected 1", n_frm - b_frm); err_cnt++; end
        cmp_cnt++;
        if ((n_par - b_par) + (n_valid - b_valid) !== 0) begin
            $display("FAIL frm_only: got %0d expected 0", (n_par - b_par) + (n_valid - b_valid));
            err_cnt++;
        end
        cmp_cnt++;
        mark();
        send_frame(mk(8'h1C, 1'b1, 1'b0), 11, -1);
        if (n_frm - b_frm !== 1) begin $display("FAIL frm_prec_pulse: got %0d expected 1", n_frm - b_frm); err_cnt++; end
        cmp_cnt++;
        if (n_par - b_par !== 0) begin $display("FAIL frm_prec_no_par: got %0d expected 0", n_par - b_par); err_cnt++; end
        cmp_cnt++;
    endtask

    task automatic test_timeout();
        ready = 1'b1;
        mark();
        send_frame(mk(8'hAA, 1'b1, 1'b1), 5, -1);
        if (busy_o !== 1'b1) begin $display("FAIL to_busy_mid: got %b expected 1", busy_o); err_cnt++; end
        cmp_cnt++;
        tick(TIMEOUT_CYC + 20);
        if (n_to - b_to !== 1) begin $display("FAIL to_pulse: got %0d expected 1", n_to - b_to); err_cnt++; end
        cmp_cnt++;
        if (busy_o !== 1'b0) begin $display("FAIL to_busy_after: got %b expected 0", busy_o); err_cnt++; end
        cmp_cnt++;
        mark();
        send_frame(mk(8'hAA, 1'b1, 1'b1), 11, -1);
        if (got_data !== 8'hAA || n_accept - b_accept !== 1) begin
            $display("FAIL to_recover: got %02h/%0d expected aa/1", got_data, n_accept - b_accept);
            err_cnt++;
        end
        cmp_cnt++;
    endtask

    task automatic test_glitch();
        ready = 1'b1;
        mark();
        send_frame(mk(8'h55, 1'b1, 1'b1), 11, 4);
        if (got_data !== 8'h55 || n_accept - b_accept !== 1) begin
            $display("FAIL glitch_data: got %02h/%0d expected 55/1", got_data, n_accept - b_accept);
            err_cnt++;
        end
        cmp_cnt++;
        if ((n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) !== 0) begin
            $display("FAIL glitch_no_err: got %0d expected 0", (n_par - b_par) + (n_frm - b_frm) + (n_to - b_to));
            err_cnt++;
        end
        cmp_cnt++;
    endtask

    task automatic test_abort(input logic use_reset);
        ready = 1'b1;
        mark();
        send_frame(mk(8'h12, 1'b1, 1'b1), 5, -1);
        if (use_reset) hrst = 1'b1; else en = 1'b0;
        tick(2);
        if (busy_o !== 1'b0) begin $display("FAIL abort_busy(rst=%0b): got %b expected 0", use_reset, busy_o); err_cnt++; end
        cmp_cnt++;
        hrst = 1'b0;
        en = 1'b1;
        tick(TIMEOUT_CYC + 20);
        if ((n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf) + (n_valid - b_valid) !== 0) begin
            $display("FAIL abort_silent(rst=%0b): got %0d expected 0", use_reset,
                     (n_par - b_par) + (n_frm - b_frm) + (n_to - b_to) + (n_ovf - b_ovf) + (n_valid - b_valid));
            err_cnt++;
        end
        cmp_cnt++;
        mark();
        send_frame(mk(8'h12, 1'b1, 1'b1), 11, -1);
        if (got_data !== 8'h12 || n_accept - b_accept !== 1) begin
            $display("FAIL abort_next(rst=%0b): got %02h/%0d expected 12/1", use_reset, got_data, n_accept - b_accept);
            err_cnt++;
        end
        cmp_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_overflow();
        test_errors();
        test_timeout();
        test_glitch();
        test_abort(1'b1);
        test_abort(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
